uart_rx_ctrl: RTL and testbench
===============================

// Module: uart_rx_ctrl
// PURPOSE
//  - UART receive controller. Detects the start bit, runs the per-bit edge counter and bit counter,
//    and drives edge_count/data_sample_en/prescale into the 3-sample majority-vote sampler.
//  - Consumes the sampler's sampled_bit, deserialises LSB-first, checks parity and stop bit.
//  - Presents P_DATA with a one-cycle data_valid. Sits between the RX_IN synchroniser and the system-control FIFO.
// PARAMETERS
//  DATA_WIDTH  8  data bits per frame
//  PRSC_W      6  width of prescale/edge_count
// PORTS
//  clk             in   1           system/UART RX clock
//  rst             in   1           synchronous, active-low reset
//  RX_IN           in   1           synchronised serial input, idle high
//  prescale        in   PRSC_W      oversampling ratio; legal values 8, 16, 32
//  PAR_EN          in   1           1 = parity bit present
//  PAR_TYP         in   1           0 = even, 1 = odd
//  sampled_bit     in   1           majority-voted bit from the sampler
//  data_sample_en  out  1           sampler enable, high in every non-IDLE state
//  edge_count      out  PRSC_W      edge counter, 0..prescale_q-1
//  samp_prescale   out  PRSC_W      prescale_q, the frame-latched prescale fed to the sampler
//  P_DATA          out  DATA_WIDTH  last good byte
//  data_valid      out  1           1-cycle pulse, P_DATA updated
//  par_err         out  1           1-cycle pulse, parity mismatch
//  stp_err         out  1           1-cycle pulse, stop bit sampled 0
//  brk_det         out  1           1-cycle pulse, break detected (macro only; else tied 0)
//  busy            out  1           high in any non-IDLE state
// BEHAVIOUR
//  - Reset (rst=0 at a clk edge): state=IDLE; all outputs 0; counters 0; shift register 0; prescale_q=8.
//    Applies mid-frame too: the frame is abandoned and no pulses are issued.
//  - States: IDLE, START, DATA, PARITY, STOP.
//  - bit_end = (edge_count == prescale_q-1).
//  - edge_count:
//    - held at 0 in IDLE;
//    - otherwise increments each cycle and wraps to 0 on bit_end.
//  - IDLE:
//    - prescale_q <= prescale every cycle.
//    - RX_IN==0 -> START; edge_count is 0 in the first START cycle.
//  - START: on bit_end, sampled_bit==0 -> DATA; sampled_bit==1 -> IDLE (glitch: no pulses, no data change).
//  - DATA:
//    - on bit_end: shreg <= {sampled_bit, shreg[DW-1:1]}; bit_cnt++.
//    - after the DATA_WIDTH-th bit, bit_cnt clears; PAR_EN ? PARITY : STOP.
//  - PARITY: on bit_end, par_bad_q <= (sampled_bit != (^shreg ^ PAR_TYP)) -> STOP.
//  - STOP, on bit_end:
//    - stp_bad = ~sampled_bit.
//    - Next cycle: pulse par_err = par_bad_q, stp_err = stp_bad.
//    - If neither error, P_DATA <= shreg and pulse data_valid (same cycle as the error pulses would be).
//    - Next state: START if RX_IN==0 at bit_end (back-to-back frame, edge_count restarts at 0), else IDLE.
//  - par_bad_q clears on entry to START. With PAR_EN=0, par_err never pulses.
//  - prescale, PAR_EN and PAR_TYP changes while busy:
//    - prescale: ignored, latched only in IDLE.
//    - PAR_EN, PAR_TYP: sampled at the DATA->PARITY/STOP decision and at the parity compare.
//  - Timing: frame end to data_valid is 1 cycle. Latency from START entry to data_valid = (DW+2+PAR_EN)*prescale_q cycles.
//  - P_DATA holds its value between valid frames; errored frames never overwrite it.
// CONFIGURATION
//  UART_RX_BREAK_DET_EN defined:
//   - Frame condition: shreg==0, parity bit 0 (if enabled) and stop bit 0.
//   - Response: brk_det pulses instead of stp_err/par_err; no data_valid.
//   - The FSM stays in IDLE until RX_IN has been 1 for one full cycle before a new start is accepted.
//  UART_RX_BREAK_DET_EN undefined:
//   - brk_det is constant 0.
//   - The frame is reported as a normal stop error.
//   - No RX_IN-high wait is required.
// TESTING
//  1. prescale=8, PAR_EN=1 even, send 0xA5, P=0, stop=1 -> data_valid 1 cycle, P_DATA=0xA5, 88 cycles after START entry.
//  2. prescale=16, PAR_EN=1 odd, send 0x3C with parity bit 0 -> par_err pulse, no data_valid, P_DATA unchanged.
//  3. prescale=32, PAR_EN=0, send 0x81 with stop=0 -> stp_err pulse, no data_valid; next good frame 0x7E -> data_valid, P_DATA=0x7E.
//  4. RX_IN low for 2 cycles then high (prescale=8) -> START then IDLE; busy drops, no pulses.
//  5. Back-to-back frames 0x11, 0x22 with no idle gap -> two data_valid pulses exactly 80 cycles apart (prescale=8, no parity).
//  6. rst=0 mid-DATA, then a good frame 0x5A -> outputs 0 during reset; then exactly one data_valid with P_DATA=0x5A.
//     With macro: all-zero frame, stop=0 -> brk_det pulse only.

Source files
------------

// File: rtl/uart_rx_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ctrl_if
// Brief   : Serial input, sampler hookup, configuration and result signals
//           of the UART receive controller.
// Revision: 1.0 - initial release
// ============================================================================
interface uart_rx_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int PRSC_W     = 6
);
    logic                  RX_IN;
    logic [PRSC_W-1:0]     prescale;
    logic                  PAR_EN;
    logic                  PAR_TYP;
    logic                  sampled_bit;
    logic                  data_sample_en;
    logic [PRSC_W-1:0]     edge_count;
    logic [PRSC_W-1:0]     samp_prescale;
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  data_valid;
    logic                  par_err;
    logic                  stp_err;
    logic                  brk_det;
    logic                  busy;

    // Environment side: line, sampler result and configuration.
    modport master (
        output RX_IN, prescale, PAR_EN, PAR_TYP, sampled_bit,
        input  data_sample_en, edge_count, samp_prescale, P_DATA,
               data_valid, par_err, stp_err, brk_det, busy
    );

    // Receive controller side.
    modport slave (
        input  RX_IN, prescale, PAR_EN, PAR_TYP, sampled_bit,
        output data_sample_en, edge_count, samp_prescale, P_DATA,
               data_valid, par_err, stp_err, brk_det, busy
    );
endinterface
`default_nettype wire

// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : uart_rx_ctrl
// Brief   : UART receive controller: start detect, bit timing, LSB-first
//           deserialise, parity/stop check. Optional break detection is
//           enabled by defining UART_RX_BREAK_DET_EN.
// Revision: 1.0 - initial release
// ============================================================================
module uart_rx_ctrl #(
    parameter int DATA_WIDTH = 8,
    parameter int PRSC_W     = 6
) (
    input  logic          clk,
    input  logic          rst,
    uart_rx_ctrl_if.slave bus
);
    localparam int c_CNT_W = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    logic [PRSC_W-1:0]     r_edge_cnt;
    logic [PRSC_W-1:0]     r_prescale_q;
    logic [c_CNT_W-1:0]    r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shreg;
    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_par_bad;
    logic                  r_data_valid;
    logic                  r_par_err;
    logic                  r_stp_err;

    logic                  w_bit_end;
    logic                  w_stp_bad;
    logic                  w_good;

    assign w_bit_end = (r_edge_cnt == (r_prescale_q - PRSC_W'(1)));
    assign w_stp_bad = ~bus.sampled_bit;
    assign w_good    = ~r_par_bad & ~w_stp_bad;

`ifdef UART_RX_BREAK_DET_EN
    logic r_brk;
    logic r_brk_wait;
    logic r_par_bit;
    logic w_brk_frame;

    // Parity bit register stays 0 when no parity bit was received.
    assign w_brk_frame = (r_shreg == '0) & ~r_par_bit & w_stp_bad;
    assign bus.brk_det = r_brk;
`else
    assign bus.brk_det = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= S_IDLE;
            r_edge_cnt   <= '0;
            r_prescale_q <= PRSC_W'(8);
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            r_data       <= '0;
            r_par_bad    <= 1'b0;
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_brk        <= 1'b0;
            r_brk_wait   <= 1'b0;
            r_par_bit    <= 1'b0;
`endif
        end else begin
            r_data_valid <= 1'b0;
            r_par_err    <= 1'b0;
            r_stp_err    <= 1'b0;
`ifdef UART_RX_BREAK_DET_EN
            r_brk        <= 1'b0;
`endif
            if (r_state == S_IDLE || w_bit_end)
                r_edge_cnt <= '0;
            else
                r_edge_cnt <= r_edge_cnt + PRSC_W'(1);

            case (r_state)
                S_IDLE: begin
                    r_prescale_q <= bus.prescale;
`ifdef UART_RX_BREAK_DET_EN
                    if (r_brk_wait) begin
                        if (bus.RX_IN) r_brk_wait <= 1'b0;
                    end else if (!bus.RX_IN) begin
                        r_state   <= S_START;
                        r_par_bad <= 1'b0;
                        r_par_bit <= 1'b0;
                    end
`else
                    if (!bus.RX_IN) begin
                        r_state   <= S_START;
                        r_par_bad <= 1'b0;
                    end
`endif
                end
                S_START: begin
                    if (w_bit_end)
                        r_state <= bus.sampled_bit ? S_IDLE : S_DATA;
                end
                S_DATA: begin
                    if (w_bit_end) begin
                        r_shreg <= {bus.sampled_bit, r_shreg[DATA_WIDTH-1:1]};
                        if (r_bit_cnt == c_CNT_W'(DATA_WIDTH - 1)) begin
                            r_bit_cnt <= '0;
                            r_state   <= bus.PAR_EN ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + c_CNT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (w_bit_end) begin
                        r_par_bad <= (bus.sampled_bit != (^r_shreg ^ bus.PAR_TYP));
`ifdef UART_RX_BREAK_DET_EN
                        r_par_bit <= bus.sampled_bit;
`endif
                        r_state   <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_bit_end) begin
`ifdef UART_RX_BREAK_DET_EN
                        if (w_brk_frame) begin
                            r_brk      <= 1'b1;
                            r_brk_wait <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_par_err <= r_par_bad;
                            r_stp_err <= w_stp_bad;
                            if (w_good) begin
                                r_data       <= r_shreg;
                                r_data_valid <= 1'b1;
                            end
                            // Low line at stop end is the next frame's start bit.
                            r_state   <= bus.RX_IN ? S_IDLE : S_START;
                            r_par_bad <= 1'b0;
                            r_par_bit <= 1'b0;
                        end
`else
                        r_par_err <= r_par_bad;
                        r_stp_err <= w_stp_bad;
                        if (w_good) begin
                            r_data       <= r_shreg;
                            r_data_valid <= 1'b1;
                        end
                        // Low line at stop end is the next frame's start bit.
                        r_state   <= bus.RX_IN ? S_IDLE : S_START;
                        r_par_bad <= 1'b0;
`endif
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy           = (r_state != S_IDLE);
    assign bus.data_sample_en = (r_state != S_IDLE);
    assign bus.edge_count     = r_edge_cnt;
    assign bus.samp_prescale  = r_prescale_q;
    assign bus.P_DATA         = r_data;
    assign bus.data_valid     = r_data_valid;
    assign bus.par_err        = r_par_err;
    assign bus.stp_err        = r_stp_err;
endmodule
`default_nettype wire

// File: tb/tb_uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_uart_rx_ctrl
// Brief   : Directed self-checking bench for uart_rx_ctrl with a one-cycle
//           delayed line copy standing in for the majority-vote sampler.
// Revision: 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_uart_rx_ctrl;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;

    int          dv_cnt, pe_cnt, se_cnt, bk_cnt, start_cyc;
    int          dv_cyc [4];
    logic [7:0]  dv_data[4];
    logic        busy_q = 1'b0;

    uart_rx_ctrl_if #(.DATA_WIDTH(8), .PRSC_W(6)) u_if ();

    uart_rx_ctrl #(.DATA_WIDTH(8), .PRSC_W(6)) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (u_if.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial u_if.sampled_bit = 1'b1;
    always @(posedge clk) u_if.sampled_bit <= u_if.RX_IN;

    always @(posedge clk) begin
        #1;
        if (u_if.data_valid) begin
            if (dv_cnt < 4) begin
                dv_cyc[dv_cnt]  = cyc;
                dv_data[dv_cnt] = u_if.P_DATA;
            end
            dv_cnt++;
        end
        if (u_if.par_err) pe_cnt++;
        if (u_if.stp_err) se_cnt++;
        if (u_if.brk_det) bk_cnt++;
        if (u_if.busy && !busy_q) start_cyc = cyc;
        busy_q = u_if.busy;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic clear_counts();
        dv_cnt = 0; pe_cnt = 0; se_cnt = 0; bk_cnt = 0; start_cyc = -1;
    endtask

    task automatic send_bit(input logic b, input int p);
        u_if.RX_IN = b;
        repeat (p) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic pe, input logic pb,
                              input logic sb, input int p);
        send_bit(1'b0, p);
        for (int i = 0; i < 8; i++) send_bit(d[i], p);
        if (pe) send_bit(pb, p);
        send_bit(sb, p);
        u_if.RX_IN = 1'b1;
    endtask

    task automatic idle(input int n);
        u_if.RX_IN = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        u_if.RX_IN    = 1'b1;
        u_if.prescale = 6'd16;
        u_if.PAR_EN   = 1'b0;
        u_if.PAR_TYP  = 1'b0;
        clear_counts();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy",     32'(u_if.busy), 32'd0);
        check_eq("rst_sampen",   32'(u_if.data_sample_en), 32'd0);
        check_eq("rst_edge",     32'(u_if.edge_count), 32'd0);
        check_eq("rst_prescale", 32'(u_if.samp_prescale), 32'd8);
        check_eq("rst_pdata",    32'(u_if.P_DATA), 32'd0);
        check_eq("rst_dv",       32'(u_if.data_valid), 32'd0);
        rst = 1'b1;
        idle(3);
        check_eq("idle_prescale", 32'(u_if.samp_prescale), 32'd16);

        // 1: prescale 8, even parity, 0xA5
        u_if.prescale = 6'd8; u_if.PAR_EN = 1'b1; u_if.PAR_TYP = 1'b0;
        idle(3); clear_counts();
        send_frame(8'hA5, 1'b1, 1'b0, 1'b1, 8);
        idle(5);
        check_eq("t1_dv_cnt",  32'(dv_cnt), 32'd1);
        check_eq("t1_pdata",   32'(u_if.P_DATA), 32'hA5);
        check_eq("t1_latency", 32'(dv_cyc[0] - start_cyc), 32'd88);
        check_eq("t1_errs",    32'(pe_cnt + se_cnt + bk_cnt), 32'd0);
        check_eq("t1_busy",    32'(u_if.busy), 32'd0);

        // 2: prescale 16, odd parity, 0x3C with wrong parity bit 0
        u_if.prescale = 6'd16; u_if.PAR_TYP = 1'b1;
        idle(3); clear_counts();
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 16);
        idle(5);
        check_eq("t2_par_err", 32'(pe_cnt), 32'd1);
        check_eq("t2_dv_cnt",  32'(dv_cnt), 32'd0);
        check_eq("t2_stp_err", 32'(se_cnt), 32'd0);
        check_eq("t2_pdata",   32'(u_if.P_DATA), 32'hA5);

        // 3: prescale 32, no parity, 0x81 bad stop then 0x7E good
        u_if.prescale = 6'd32; u_if.PAR_EN = 1'b0;
        idle(3); clear_counts();
        send_frame(8'h81, 1'b0, 1'b0, 1'b0, 32);
        idle(5);
        check_eq("t3_stp_err", 32'(se_cnt), 32'd1);
        check_eq("t3_dv_cnt",  32'(dv_cnt), 32'd0);
        check_eq("t3_par_err", 32'(pe_cnt), 32'd0);
        check_eq("t3_pdata",   32'(u_if.P_DATA), 32'hA5);
        clear_counts();
        send_frame(8'h7E, 1'b0, 1'b0, 1'b1, 32);
        idle(5);
        check_eq("t3b_dv_cnt",  32'(dv_cnt), 32'd1);
        check_eq("t3b_pdata",   32'(u_if.P_DATA), 32'h7E);
        check_eq("t3b_latency", 32'(dv_cyc[0] - start_cyc), 32'd320);

        // 4: start glitch, prescale 8
        u_if.prescale = 6'd8;
        idle(3); clear_counts();
        send_bit(1'b0, 2);
        u_if.RX_IN = 1'b1;
        @(negedge clk);
        check_eq("t4_busy_start", 32'(u_if.busy), 32'd1);
        idle(10);
        check_eq("t4_busy_drop", 32'(u_if.busy), 32'd0);
        check_eq("t4_pulses",    32'(dv_cnt + pe_cnt + se_cnt + bk_cnt), 32'd0);
        check_eq("t4_pdata",     32'(u_if.P_DATA), 32'h7E);

        // 5: back-to-back frames, prescale 8, no parity
        clear_counts();
        send_frame(8'h11, 1'b0, 1'b0, 1'b1, 8);
        send_frame(8'h22, 1'b0, 1'b0, 1'b1, 8);
        idle(5);
        check_eq("t5_dv_cnt", 32'(dv_cnt), 32'd2);
        check_eq("t5_data0",  32'(dv_data[0]), 32'h11);
        check_eq("t5_data1",  32'(dv_data[1]), 32'h22);
        check_eq("t5_gap",    32'(dv_cyc[1] - dv_cyc[0]), 32'd80);

        // 6: reset mid-DATA, then a good frame
        clear_counts();
        send_bit(1'b0, 8);
        for (int i = 0; i < 3; i++) send_bit(1'b0, 8);
        check_eq("t6_busy_pre", 32'(u_if.busy), 32'd1);
        u_if.RX_IN = 1'b1;
        rst = 1'b0;
        repeat (3) @(negedge clk);
        check_eq("t6_rst_busy",  32'(u_if.busy), 32'd0);
        check_eq("t6_rst_edge",  32'(u_if.edge_count), 32'd0);
        check_eq("t6_rst_pdata", 32'(u_if.P_DATA), 32'd0);
        check_eq("t6_rst_pulse", 32'(u_if.data_valid | u_if.stp_err | u_if.par_err), 32'd0);
        rst = 1'b1;
        idle(3);
        check_eq("t6_no_pulse", 32'(dv_cnt + pe_cnt + se_cnt + bk_cnt), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b0, 1'b1, 8);
        idle(5);
        check_eq("t6_dv_cnt", 32'(dv_cnt), 32'd1);
        check_eq("t6_pdata",  32'(u_if.P_DATA), 32'h5A);

        // 7: all-zero frame with stop 0
        clear_counts();
`ifdef UART_RX_BREAK_DET_EN
        send_bit(1'b0, 8);
        for (int i = 0; i < 8; i++) send_bit(1'b0, 8);
        send_bit(1'b0, 8);
        send_bit(1'b0, 10);
        check_eq("t7_hold_idle", 32'(u_if.busy), 32'd0);
        idle(5);
        check_eq("t7_brk",   32'(bk_cnt), 32'd1);
        check_eq("t7_stp",   32'(se_cnt + pe_cnt), 32'd0);
        check_eq("t7_dv",    32'(dv_cnt), 32'd0);
`else
        send_frame(8'h00, 1'b0, 1'b0, 1'b0, 8);
        idle(5);
        check_eq("t7_stp",   32'(se_cnt), 32'd1);
        check_eq("t7_brk",   32'(bk_cnt), 32'd0);
        check_eq("t7_dv",    32'(dv_cnt), 32'd0);
`endif
        check_eq("t7_pdata", 32'(u_if.P_DATA), 32'h5A);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
